// File: rtl/video_mixer_nch.sv
// rtl/video_mixer_nch.sv - N-source RGB mixer with vsync-shadowed controls and bit-replicated output.
// Optional field blink via VIDEO_MIXER_BLINK_EN.
module video_mixer_nch #(
  parameter int NUM_SOURCES = 2,
  parameter int BITS_IN     = 1,
  parameter int BITS_OUT    = 6
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               pixelEn,
  input  logic                               vsync,
  input  logic                               displayEnableIn,
  input  logic [NUM_SOURCES*3*BITS_IN-1:0]   sourcesIn,
  input  logic [NUM_SOURCES-1:0]             sourceEnable,
  input  logic [1:0]                         mode,
  input  logic [3*BITS_IN-1:0]               keyColour,
  input  logic [2:0]                         forceSel,
`ifdef VIDEO_MIXER_BLINK_EN
  input  logic [NUM_SOURCES-1:0]             blinkMask,
`endif
  output logic [BITS_OUT-1:0]                redOut,
  output logic [BITS_OUT-1:0]                greenOut,
  output logic [BITS_OUT-1:0]                blueOut,
  output logic                               displayEnableOut
);

  localparam int PW = 3 * BITS_IN;
  localparam int SW = NUM_SOURCES * PW;

  typedef enum logic [1:0] {
    M_PRIORITY = 2'd0,
    M_KEY      = 2'd1,
    M_XOR      = 2'd2,
    M_FORCE    = 2'd3
  } mode_t;

  logic                   vsync_q;
  logic                   vs_rise;
  logic [NUM_SOURCES-1:0] sh_en;
  mode_t                  sh_mode;
  logic [PW-1:0]          sh_key;
  logic [2:0]             sh_force;
  logic [NUM_SOURCES-1:0] en_eff;

  assign vs_rise = vsync & ~vsync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vsync_q  <= 1'b0;
      sh_en    <= '0;
      sh_mode  <= M_PRIORITY;
      sh_key   <= '0;
      sh_force <= '0;
    end else begin
      vsync_q <= vsync;
      if (vs_rise) begin
        sh_en    <= sourceEnable;
        sh_mode  <= mode_t'(mode);
        sh_key   <= keyColour;
        sh_force <= forceSel;
      end
    end
  end

`ifdef VIDEO_MIXER_BLINK_EN
  logic [NUM_SOURCES-1:0] sh_blink;
  logic [4:0]             field_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_blink  <= '0;
      field_cnt <= '0;
    end else if (vs_rise) begin
      sh_blink  <= blinkMask;
      field_cnt <= field_cnt + 5'd1;
    end
  end

  assign en_eff = sh_en & ~(field_cnt[4] ? sh_blink : '0);
`else
  assign en_eff = sh_en;
`endif

  // Controls travel with the pixel so a vsync edge never retimes pixels already in flight.
  logic [SW-1:0]          s1_pix;
  logic                   s1_de;
  logic [NUM_SOURCES-1:0] s1_en;
  mode_t                  s1_mode;
  logic [PW-1:0]          s1_key;
  logic [2:0]             s1_force;
  logic [NUM_SOURCES-1:0] non_black;
  logic [NUM_SOURCES-1:0] not_key;
  logic [PW-1:0]          sel;
  logic [PW-1:0]          s2_col;
  logic                   s2_de;

  always_comb begin
    non_black = '0;
    not_key   = '0;
    for (int s = 0; s < NUM_SOURCES; s++) begin
      non_black[s] = |s1_pix[s*PW +: PW];
      not_key[s]   = s1_pix[s*PW +: PW] != s1_key;
    end
  end

  // Ascending scans let the highest-index qualifying source win.
  always_comb begin
    sel = '0;
    case (s1_mode)
      M_PRIORITY: begin
        for (int s = 0; s < NUM_SOURCES; s++)
          if (s1_en[s] && non_black[s]) sel = s1_pix[s*PW +: PW];
      end
      M_KEY: begin
        if (s1_en[0]) sel = s1_pix[PW-1:0];
        for (int s = 1; s < NUM_SOURCES; s++)
          if (s1_en[s] && not_key[s]) sel = s1_pix[s*PW +: PW];
      end
      M_XOR: begin
        for (int s = 0; s < NUM_SOURCES; s++)
          if (s1_en[s]) sel = sel ^ s1_pix[s*PW +: PW];
      end
      default: begin
        for (int s = 0; s < NUM_SOURCES; s++)
          if ((int'(s1_force) == s) && s1_en[s]) sel = s1_pix[s*PW +: PW];
      end
    endcase
  end

  function automatic logic [BITS_OUT-1:0] expand(input logic [BITS_IN-1:0] c);
    logic [BITS_OUT-1:0] r;
    r = '0;
    for (int i = 0; i < BITS_OUT; i++)
      r[BITS_OUT-1-i] = c[BITS_IN-1-(i % BITS_IN)];
    return r;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_pix           <= '0;
      s1_de            <= 1'b0;
      s1_en            <= '0;
      s1_mode          <= M_PRIORITY;
      s1_key           <= '0;
      s1_force         <= '0;
      s2_col           <= '0;
      s2_de            <= 1'b0;
      redOut           <= '0;
      greenOut         <= '0;
      blueOut          <= '0;
      displayEnableOut <= 1'b0;
    end else if (pixelEn) begin
      s1_pix           <= sourcesIn;
      s1_de            <= displayEnableIn;
      s1_en            <= en_eff;
      s1_mode          <= sh_mode;
      s1_key           <= sh_key;
      s1_force         <= sh_force;
      s2_col           <= sel;
      s2_de            <= s1_de;
      redOut           <= s2_de ? expand(s2_col[3*BITS_IN-1:2*BITS_IN]) : '0;
      greenOut         <= s2_de ? expand(s2_col[2*BITS_IN-1:BITS_IN])   : '0;
      blueOut          <= s2_de ? expand(s2_col[BITS_IN-1:0])           : '0;
      displayEnableOut <= s2_de;
    end
  end

endmodule
